// File: rtl/mesh_nic.sv
// PE-side network interface: inbound and outbound packet FIFOs between a processor
// register port and one mesh router PE port, with VC/polarity-gated injection.

module nic_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [IW-1:0] widx, ridx;
  logic [W-1:0]  mem_q [DEPTH];

  // With a single entry there is no index; the lone pointer bit only marks full/empty.
  assign widx = (DEPTH == 1) ? '0 : wr_q[IW-1:0];
  assign ridx = (DEPTH == 1) ? '0 : rd_q[IW-1:0];

  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (count_o == PW'(DEPTH));
  assign head_o  = mem_q[ridx];

  assign wr_d = push_i ? wr_q + 1'b1 : wr_q;
  assign rd_d = pop_i  ? rd_q + 1'b1 : rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[widx] <= din_i;
  end
endmodule

module mesh_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_polarity,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] in_head, out_head, d_out_q, d_out_d;
  logic                  in_empty, in_full, out_empty, out_full;
  logic [PW-1:0]         in_count, out_count;
  logic                  in_push, in_pop, out_push, out_pop;
  logic                  rd_en, wr_en;

  assign rd_en = nicEn & ~nicWrEn;
  assign wr_en = nicEn & nicWrEn;

  // Full/empty are judged on pre-edge state, so a write into a full out FIFO is
  // dropped even when the router drains an entry on the same edge.
  assign in_push  = net_si & ~in_full;
  assign in_pop   = rd_en & (addr == 2'b00) & ~in_empty;
  assign out_push = wr_en & (addr == 2'b10) & ~out_full;
  assign out_pop  = net_so & net_ro;

  nic_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_in (
    .clk(clk), .rst_n(reset), .push_i(in_push), .din_i(net_di), .pop_i(in_pop),
    .head_o(in_head), .empty_o(in_empty), .full_o(in_full), .count_o(in_count)
  );

  nic_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_out (
    .clk(clk), .rst_n(reset), .push_i(out_push), .din_i(d_in), .pop_i(out_pop),
    .head_o(out_head), .empty_o(out_empty), .full_o(out_full), .count_o(out_count)
  );

  assign net_ri = ~in_full;
  assign net_do = out_empty ? '0 : out_head;
  assign net_so = ~out_empty & (out_head[DATA_WIDTH-1] == net_polarity);

  always_comb begin
    d_out_d = d_out_q;
    if (rd_en) begin
      case (addr)
        2'b00: d_out_d = in_empty ? '0 : in_head;
        2'b01: begin
          d_out_d = '0;
          d_out_d[PW+1:0] = {in_count, in_full, ~in_empty};
        end
        2'b11: begin
          d_out_d = '0;
          d_out_d[PW+1:0] = {out_count, out_full, out_empty};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_out_q <= '0;
    else        d_out_q <= d_out_d;
  end

  assign d_out = d_out_q;
endmodule

// File: tb/tb_mesh_nic.sv
// Bench for mesh_nic: a DEPTH=1 and a DEPTH=4 instance share all inputs; each scenario
// checks the instance it targets against an expected-packet queue.

module tb_mesh_nic;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   addr;
  logic [W-1:0] d_in, net_di;
  logic         nicEn, nicWrEn, net_polarity, net_si, net_ro;
  logic [W-1:0] d_out1, net_do1, d_out4, net_do4;
  logic         net_ri1, net_so1, net_ri4, net_so4;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  mesh_nic #(.DATA_WIDTH(W), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out1),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_polarity(net_polarity),
    .net_si(net_si), .net_ri(net_ri1), .net_di(net_di),
    .net_so(net_so1), .net_ro(net_ro), .net_do(net_do1)
  );

  mesh_nic #(.DATA_WIDTH(W), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out4),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_polarity(net_polarity),
    .net_si(net_si), .net_ri(net_ri4), .net_di(net_di),
    .net_so(net_so4), .net_ro(net_ro), .net_do(net_do4)
  );

  // ---------------- driver tasks (all run at posedge+1) ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    cyc();
    exp_q.delete();
  endtask

  task automatic reg_rd(input logic [1:0] a);
    addr = a; nicEn = 1'b1; nicWrEn = 1'b0;
    cyc();
    nicEn = 1'b0;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [W-1:0] v);
    addr = a; d_in = v; nicEn = 1'b1; nicWrEn = 1'b1;
    cyc();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  task automatic router_push(input logic [W-1:0] v);
    net_si = 1'b1; net_di = v;
    cyc();
    net_si = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    addr = 2'($urandom_range(0, 3)); nicEn = 1'b1; nicWrEn = 1'b1;
    d_in = {$urandom, $urandom}; net_di = {$urandom, $urandom};
    net_si = 1'b1; net_ro = 1'b1; net_polarity = 1'b1;
    #3;
    n_cmp++; if (net_ri1 !== 1'b1) begin n_err++; $display("FAIL reset_ri got=%b exp=1", net_ri1); end
    n_cmp++; if (net_so1 !== 1'b0) begin n_err++; $display("FAIL reset_so got=%b exp=0", net_so1); end
    n_cmp++; if (d_out1 !== '0) begin n_err++; $display("FAIL reset_dout got=%h exp=0", d_out1); end
    n_cmp++; if (net_do1 !== '0) begin n_err++; $display("FAIL reset_do got=%h exp=0", net_do1); end
    @(negedge clk);
    idle();
    reset = 1'b1;
    cyc();
    reg_rd(2'b11);
    n_cmp++; if (d_out1 !== 64'h1) begin n_err++; $display("FAIL reset_outstat1 got=%h exp=1", d_out1); end
    n_cmp++; if (d_out4 !== 64'h1) begin n_err++; $display("FAIL reset_outstat4 got=%h exp=1", d_out4); end
  endtask

  task automatic test_outbound();
    do_reset();
    net_ro = 1'b1; net_polarity = 1'b0;
    reg_wr(2'b10, 64'h8000_0000_0000_00AB);
    exp_q.push_back(64'h8000_0000_0000_00AB);
    cyc(); cyc();
    n_cmp++; if (net_so1 !== 1'b0) begin n_err++; $display("FAIL out_vc_wait got=%b exp=0", net_so1); end
    net_polarity = 1'b1;
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++; if (net_so1 !== 1'b1) begin n_err++; $display("FAIL out_so got=%b exp=1", net_so1); end
    n_cmp++; if (net_do1 !== exp_v) begin n_err++; $display("FAIL out_data got=%h exp=%h", net_do1, exp_v); end
    cyc();
    n_cmp++; if (net_so1 !== 1'b0) begin n_err++; $display("FAIL out_once got=%b exp=0", net_so1); end
    n_cmp++; if (net_do1 !== '0) begin n_err++; $display("FAIL out_do_zero got=%h exp=0", net_do1); end
    reg_rd(2'b11);
    n_cmp++; if (d_out1 !== 64'h1) begin n_err++; $display("FAIL out_empty got=%h exp=1", d_out1); end
  endtask

  task automatic test_inbound();
    do_reset();
    router_push(64'h1234);
    exp_q.push_back(64'h1234);
    n_cmp++; if (net_ri1 !== 1'b0) begin n_err++; $display("FAIL in_ri_full got=%b exp=0", net_ri1); end
    reg_rd(2'b01);
    n_cmp++; if (d_out1 !== 64'h7) begin n_err++; $display("FAIL in_stat got=%h exp=7", d_out1); end
    reg_rd(2'b00);
    exp_v = exp_q.pop_front();
    n_cmp++; if (d_out1 !== exp_v) begin n_err++; $display("FAIL in_data got=%h exp=%h", d_out1, exp_v); end
    n_cmp++; if (net_ri1 !== 1'b1) begin n_err++; $display("FAIL in_ri_free got=%b exp=1", net_ri1); end
    reg_rd(2'b00);
    n_cmp++; if (d_out1 !== '0) begin n_err++; $display("FAIL in_empty_read got=%h exp=0", d_out1); end
  endtask

  task automatic test_backpressure();
    int sent;
    do_reset();
    reg_wr(2'b10, 64'h0000_0000_0000_0A0A);
    exp_q.push_back(64'h0000_0000_0000_0A0A);
    reg_wr(2'b10, 64'h0000_0000_0000_0B0B);
    reg_rd(2'b11);
    n_cmp++; if (d_out1 !== 64'h6) begin n_err++; $display("FAIL bp_stat got=%h exp=6", d_out1); end
    net_ro = 1'b1;
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++; if (net_do1 !== exp_v) begin n_err++; $display("FAIL bp_first got=%h exp=%h", net_do1, exp_v); end
    sent = 0;
    for (int i = 0; i < 5; i++) begin
      if (net_so1) sent++;
      cyc();
    end
    n_cmp++; if (sent !== 1) begin n_err++; $display("FAIL bp_count got=%0d exp=1", sent); end
    // Full at the edge while the router drains: the write must still be dropped.
    net_ro = 1'b0;
    reg_wr(2'b10, 64'h0000_0000_0000_0C0C);
    net_ro = 1'b1;
    reg_wr(2'b10, 64'h0000_0000_0000_0D0D);
    net_ro = 1'b0;
    reg_rd(2'b11);
    n_cmp++; if (d_out1 !== 64'h1) begin n_err++; $display("FAIL bp_full_drop got=%h exp=1", d_out1); end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] v;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      v = {$urandom, $urandom};
      router_push(v); exp_q.push_back(v);
    end
    reg_rd(2'b01);
    n_cmp++; if (d_out4 !== 64'h9) begin n_err++; $display("FAIL sim_stat2 got=%h exp=9", d_out4); end
    v = {$urandom, $urandom};
    net_si = 1'b1; net_di = v; exp_q.push_back(v);
    reg_rd(2'b00);
    net_si = 1'b0;
    exp_v = exp_q.pop_front();
    n_cmp++; if (d_out4 !== exp_v) begin n_err++; $display("FAIL sim_pop got=%h exp=%h", d_out4, exp_v); end
    reg_rd(2'b01);
    n_cmp++; if (d_out4 !== 64'h9) begin n_err++; $display("FAIL sim_count got=%h exp=9", d_out4); end
    for (int r = 0; r < 2; r++) begin
      while (exp_q.size() < 4) begin
        v = {$urandom, $urandom};
        router_push(v); exp_q.push_back(v);
      end
      n_cmp++; if (net_ri4 !== 1'b0) begin n_err++; $display("FAIL sim_full_ri got=%b exp=0", net_ri4); end
      reg_rd(2'b01);
      n_cmp++; if (d_out4 !== 64'h13) begin n_err++; $display("FAIL sim_stat4 got=%h exp=13", d_out4); end
      for (int i = 0; i < 4; i++) begin
        reg_rd(2'b00);
        exp_v = exp_q.pop_front();
        n_cmp++; if (d_out4 !== exp_v) begin n_err++; $display("FAIL sim_drain got=%h exp=%h", d_out4, exp_v); end
      end
    end
    // Outbound: processor push and router pop on the same edge.
    v = {1'b0, 63'($urandom)};
    reg_wr(2'b10, v); exp_q.push_back(v);
    v = {1'b0, 63'($urandom)};
    net_ro = 1'b1;
    exp_v = exp_q.pop_front();
    n_cmp++; if (net_do4 !== exp_v) begin n_err++; $display("FAIL sim_out1 got=%h exp=%h", net_do4, exp_v); end
    reg_wr(2'b10, v); exp_q.push_back(v);
    exp_v = exp_q.pop_front();
    n_cmp++; if (net_do4 !== exp_v) begin n_err++; $display("FAIL sim_out2 got=%h exp=%h", net_do4, exp_v); end
    cyc();
    net_ro = 1'b0;
    reg_rd(2'b11);
    n_cmp++; if (d_out4 !== 64'h1) begin n_err++; $display("FAIL sim_out_empty got=%h exp=1", d_out4); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    reg_wr(2'b10, 64'h11);
    reg_wr(2'b10, 64'h22);
    n_cmp++; if (net_so4 !== 1'b1) begin n_err++; $display("FAIL mid_so_pre got=%b exp=1", net_so4); end
    reset = 1'b0;
    #1;
    n_cmp++; if (net_so4 !== 1'b0) begin n_err++; $display("FAIL mid_so got=%b exp=0", net_so4); end
    n_cmp++; if (net_do4 !== '0) begin n_err++; $display("FAIL mid_do got=%h exp=0", net_do4); end
    #1;
    reset = 1'b1;
    cyc();
    reg_rd(2'b11);
    n_cmp++; if (d_out4 !== 64'h1) begin n_err++; $display("FAIL mid_empty got=%h exp=1", d_out4); end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    cyc();
    test_reset();
    test_outbound();
    test_inbound();
    test_backpressure();
    test_simultaneous();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
